// File: rtl/dma_multi_channel_controller_pkg.sv
// Shared types and helpers for the multi-channel DMA controller.
// State encoding, default widths and round-robin index math.
package dma_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE
  } dma_state_e;

  localparam int DMA_NUM_CH = 4;
  localparam int DMA_DATA_W = 8;
  localparam int DMA_ADDR_W = 8;
  localparam int DMA_SIZE_W = 8;

  function automatic int rr_index(
    input int base,
    input int off,
    input int n
  );
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/dma_multi_channel_controller_if.sv
// Byte-source and memory-write bundle of the DMA controller.
// master = controller side, slave = source/memory side.
interface dma_multi_channel_controller_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] src_data;
  logic                  src_valid;
  logic                  src_ready;
  logic [ADDR_WIDTH-1:0] mem_write_address;
  logic [DATA_WIDTH-1:0] mem_write_data;
  logic                  mem_write_enable;

  modport master (
    input  src_data,
    input  src_valid,
    output src_ready,
    output mem_write_address,
    output mem_write_data,
    output mem_write_enable
  );

  modport slave (
    output src_data,
    output src_valid,
    input  src_ready,
    input  mem_write_address,
    input  mem_write_data,
    input  mem_write_enable
  );

endinterface

// File: rtl/dma_multi_channel_controller_rr_arbiter.sv
// Combinational round-robin arbiter for the DMA controller.
// Search begins at the channel after last_grant.
module dma_rr_arbiter
  import dma_pkg::*;
#(
  parameter int NUM_CH = DMA_NUM_CH,
  localparam int IW = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IW-1:0]     last_grant,
  output logic [IW-1:0]     grant,
  output logic              any_grant
);

  always_comb begin : arb
    logic [IW-1:0] sel;
    sel       = '0;
    grant     = '0;
    any_grant = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      sel = IW'(rr_index(int'(last_grant), k, NUM_CH));
      if (!any_grant && req[sel]) begin
        any_grant = 1'b1;
        grant     = sel;
      end
    end
  end

endmodule

// File: rtl/dma_multi_channel_controller.sv
// Multi-channel round-robin DMA: byte stream in, memory writes out.
// Optional abort support with `define DMA_ABORT_EN.
module dma_multi_channel_controller
  import dma_pkg::*;
#(
  parameter int NUM_CH     = DMA_NUM_CH,
  parameter int DATA_WIDTH = DMA_DATA_W,
  parameter int ADDR_WIDTH = DMA_ADDR_W,
  parameter int SIZE_WIDTH = DMA_SIZE_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            ch_start,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_start_address,
  input  logic [NUM_CH*SIZE_WIDTH-1:0] ch_transfer_size,
  input  logic [NUM_CH-1:0]            ch_fixed_addr,
  output logic [NUM_CH-1:0]            ch_busy,
  output logic [NUM_CH-1:0]            ch_done,
`ifdef DMA_ABORT_EN
  input  logic [NUM_CH-1:0]            ch_abort,
  output logic [NUM_CH-1:0]            ch_aborted,
`endif
  dma_multi_channel_controller_if.master bus,
  output logic [$clog2(NUM_CH)-1:0]    active_ch
);

  localparam int IW = $clog2(NUM_CH);

  dma_state_e state_q, state_d;

  logic [NUM_CH-1:0]     start_q, rise;
  logic [NUM_CH-1:0]     pend_q, pend_d;
  logic [NUM_CH-1:0]     done_d, req;
  logic [ADDR_WIDTH-1:0] addr_sh [NUM_CH];
  logic [SIZE_WIDTH-1:0] size_sh [NUM_CH];
  logic [NUM_CH-1:0]     fixed_sh;
  logic [ADDR_WIDTH-1:0] cur_addr_q, hold_addr_q;
  logic [SIZE_WIDTH-1:0] cnt_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [IW-1:0]         act_q, last_q, grant;
  logic                  any_grant, load, take, adv, fin;
  logic                  last_byte, abort_act;
  logic                  src_rdy, we;

  assign rise      = ch_start & ~start_q;
  assign ch_busy   = pend_q;
  assign active_ch = act_q;
  assign last_byte = (cnt_q == size_sh[act_q] - SIZE_WIDTH'(1));

`ifdef DMA_ABORT_EN
  logic [NUM_CH-1:0] abrt_d;
  assign abort_act = ch_abort[act_q] && (state_q != IDLE);
  assign req       = pend_q & ~ch_abort;
`else
  assign abort_act = 1'b0;
  assign req       = pend_q;
`endif

  dma_rr_arbiter #(
    .NUM_CH(NUM_CH)
  ) u_arb (
    .req       (req),
    .last_grant(last_q),
    .grant     (grant),
    .any_grant (any_grant)
  );

  always_comb begin
    state_d = state_q;
    src_rdy = 1'b0;
    we      = 1'b0;
    load    = 1'b0;
    take    = 1'b0;
    adv     = 1'b0;
    fin     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_grant) begin
          load    = 1'b1;
          state_d = READ;
        end
      end
      READ: begin
        src_rdy = !abort_act;
        if (abort_act) begin
          fin     = 1'b1;
          state_d = IDLE;
        end else if (bus.src_valid) begin
          take    = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        we  = 1'b1;
        adv = 1'b1;
        if (last_byte || abort_act) begin
          fin     = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.src_ready         = src_rdy;
  assign bus.mem_write_enable  = we;
  assign bus.mem_write_address = we ? cur_addr_q : hold_addr_q;
  assign bus.mem_write_data    = data_q;

  // Start edges on a busy channel are dropped; size 0 completes at once.
  always_comb begin
    pend_d = pend_q;
    done_d = '0;
`ifdef DMA_ABORT_EN
    abrt_d = '0;
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      if (rise[i] && !pend_q[i]) begin
        if (ch_transfer_size[i*SIZE_WIDTH +: SIZE_WIDTH] != '0)
          pend_d[i] = 1'b1;
        else
          done_d[i] = 1'b1;
      end
    end
`ifdef DMA_ABORT_EN
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_abort[i] && pend_q[i] &&
          !(state_q != IDLE && act_q == IW'(i))) begin
        pend_d[i] = 1'b0;
        abrt_d[i] = 1'b1;
      end
    end
`endif
    if (fin) begin
      pend_d[act_q] = 1'b0;
`ifdef DMA_ABORT_EN
      if (abort_act)
        abrt_d[act_q] = 1'b1;
      else
        done_d[act_q] = 1'b1;
`else
      done_d[act_q] = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q     <= '0;
      pend_q      <= '0;
      ch_done     <= '0;
      fixed_sh    <= '0;
      cur_addr_q  <= '0;
      hold_addr_q <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      act_q       <= '0;
      last_q      <= IW'(NUM_CH - 1);
      for (int i = 0; i < NUM_CH; i++) begin
        addr_sh[i] <= '0;
        size_sh[i] <= '0;
      end
`ifdef DMA_ABORT_EN
      ch_aborted  <= '0;
`endif
    end else begin
      start_q <= ch_start;
      pend_q  <= pend_d;
      ch_done <= done_d;
`ifdef DMA_ABORT_EN
      ch_aborted <= abrt_d;
`endif
      for (int i = 0; i < NUM_CH; i++) begin
        if (rise[i] && !pend_q[i]) begin
          addr_sh[i]  <= ch_start_address[i*ADDR_WIDTH +: ADDR_WIDTH];
          size_sh[i]  <= ch_transfer_size[i*SIZE_WIDTH +: SIZE_WIDTH];
          fixed_sh[i] <= ch_fixed_addr[i];
        end
      end
      if (load) begin
        cur_addr_q <= addr_sh[grant];
        cnt_q      <= '0;
        act_q      <= grant;
      end
      if (take)
        data_q <= bus.src_data;
      // Address shown during WRITE is held afterwards for a stable bus.
      if (adv) begin
        hold_addr_q <= cur_addr_q;
        cnt_q       <= cnt_q + SIZE_WIDTH'(1);
        if (!fixed_sh[act_q])
          cur_addr_q <= cur_addr_q + ADDR_WIDTH'(1);
      end
      if (fin)
        last_q <= act_q;
    end
  end

endmodule

// File: tb/tb_dma_multi_channel_controller.sv
// Scoreboard bench for dma_multi_channel_controller.
// Directed transfers; monitor checks every write and done pulse.
module tb_dma_multi_channel_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ch_start;
  logic [31:0] ch_addr;
  logic [31:0] ch_size;
  logic [3:0]  ch_fixed;
  logic [3:0]  ch_busy;
  logic [3:0]  ch_done;
  logic [1:0]  active_ch;
`ifdef DMA_ABORT_EN
  logic [3:0]  ch_abort;
  logic [3:0]  ch_aborted;
`endif

  logic [15:0] exp_wr[$];
  int          exp_done[$];
  logic [7:0]  src_q[$];
  bit          stall;
  logic        hs;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  dma_multi_channel_controller_if #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(8)
  ) bus ();

  dma_multi_channel_controller dut (
    .clk             (clk),
    .rst             (rst),
    .ch_start        (ch_start),
    .ch_start_address(ch_addr),
    .ch_transfer_size(ch_size),
    .ch_fixed_addr   (ch_fixed),
    .ch_busy         (ch_busy),
    .ch_done         (ch_done),
`ifdef DMA_ABORT_EN
    .ch_abort        (ch_abort),
    .ch_aborted      (ch_aborted),
`endif
    .bus             (bus),
    .active_ch       (active_ch)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    hs  <= bus.src_valid && bus.src_ready && !rst;
  end

  // Source model and monitor, both away from the active edge.
  always @(negedge clk) begin : mon
    logic [15:0] e;
    int          c;
    if (hs && src_q.size() > 0)
      void'(src_q.pop_front());
    bus.src_valid = (src_q.size() > 0) && !stall && !rst;
    bus.src_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
    if (!rst) begin
      if (bus.mem_write_enable) begin
        checks++;
        if (exp_wr.size() == 0) begin
          errors++;
          $display("FAIL write: unexpected addr=%h data=%h",
                   bus.mem_write_address, bus.mem_write_data);
        end else begin
          e = exp_wr.pop_front();
          if ({bus.mem_write_address, bus.mem_write_data} !== e) begin
            errors++;
            $display("FAIL write: got addr=%h data=%h want addr=%h data=%h",
                     bus.mem_write_address, bus.mem_write_data,
                     e[15:8], e[7:0]);
          end
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (ch_done[i]) begin
          checks++;
          if (exp_done.size() == 0) begin
            errors++;
            $display("FAIL done: unexpected ch_done[%0d]", i);
          end else begin
            c = exp_done.pop_front();
            if (c != i) begin
              errors++;
              $display("FAIL done: got ch %0d want ch %0d", i, c);
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic cfg(int ch, logic [7:0] a, logic [7:0] sz, bit fx);
    ch_addr[ch*8 +: 8] = a;
    ch_size[ch*8 +: 8] = sz;
    ch_fixed[ch]       = fx;
  endtask

  task automatic pulse(logic [3:0] m);
    ch_start = m;
    step();
    ch_start = '0;
  endtask

  task automatic wr(logic [7:0] a, logic [7:0] d);
    exp_wr.push_back({a, d});
    src_q.push_back(d);
  endtask

  task automatic drain(string name);
    int n;
    n = 0;
    while ((exp_wr.size() != 0 || exp_done.size() != 0) && n < 300) begin
      step();
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL %s: timeout, %0d writes %0d dones left",
               name, exp_wr.size(), exp_done.size());
      exp_wr.delete();
      exp_done.delete();
    end
    repeat (4) step();
  endtask

  task automatic wait_wr_left(int left, string name);
    int n;
    n = 0;
    while (exp_wr.size() > left && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout waiting for writes", name);
    end
  endtask

  initial begin
    int c0, c1, n;
    rst      = 1'b1;
    ch_start = '0;
    ch_addr  = '0;
    ch_size  = '0;
    ch_fixed = '0;
    stall    = 1'b0;
`ifdef DMA_ABORT_EN
    ch_abort = '0;
`endif
    bus.src_valid = 1'b0;
    bus.src_data  = '0;
    step();
    step();
    check("rst_src_ready", 32'(bus.src_ready), 0);
    check("rst_we", 32'(bus.mem_write_enable), 0);
    check("rst_addr", 32'(bus.mem_write_address), 0);
    check("rst_busy", 32'(ch_busy), 0);
    check("rst_done", 32'(ch_done), 0);
    rst = 1'b0;
    step();

    // Arbitration from reset: ch0 then ch1.
    cfg(0, 8'h00, 8'd2, 1'b0);
    cfg(1, 8'h20, 8'd2, 1'b0);
    wr(8'h00, 8'h11); wr(8'h01, 8'h12);
    wr(8'h20, 8'h21); wr(8'h21, 8'h22);
    exp_done.push_back(0); exp_done.push_back(1);
    pulse(4'b0011);
    check("arb_busy", 32'(ch_busy), 32'h3);
    drain("arb_a");

    // Last grant ch1: ch0 wins again.
    wr(8'h00, 8'h13); wr(8'h01, 8'h14);
    wr(8'h20, 8'h23); wr(8'h21, 8'h24);
    exp_done.push_back(0); exp_done.push_back(1);
    pulse(4'b0011);
    drain("arb_b");

    // Single transfer with done timing.
    cfg(0, 8'h10, 8'd3, 1'b0);
    wr(8'h10, 8'h41); wr(8'h11, 8'h64); wr(8'h12, 8'h76);
    exp_done.push_back(0);
    pulse(4'b0001);
    n = 0;
    while (!bus.src_ready && n < 20) begin step(); n++; end
    c0 = cyc;
    n = 0;
    while (!ch_done[0] && n < 40) begin step(); n++; end
    c1 = cyc;
    check("done_latency", 32'(c1 - c0), 32'd6);
    drain("single");

    // Last grant ch0: ch1 then ch2.
    cfg(1, 8'h20, 8'd2, 1'b0);
    cfg(2, 8'h90, 8'd2, 1'b0);
    wr(8'h20, 8'h25); wr(8'h21, 8'h26);
    wr(8'h90, 8'h31); wr(8'h91, 8'h32);
    exp_done.push_back(1); exp_done.push_back(2);
    pulse(4'b0110);
    drain("arb_c");

    // Address wrap.
    cfg(2, 8'hFE, 8'd4, 1'b0);
    wr(8'hFE, 8'hA0); wr(8'hFF, 8'hA1);
    wr(8'h00, 8'hA2); wr(8'h01, 8'hA3);
    exp_done.push_back(2);
    pulse(4'b0100);
    drain("wrap");

    // Fixed address.
    cfg(3, 8'h80, 8'd3, 1'b1);
    wr(8'h80, 8'hB0); wr(8'h80, 8'hB1); wr(8'h80, 8'hB2);
    exp_done.push_back(3);
    pulse(4'b1000);
    drain("fixed");

    // Size zero completes next cycle.
    cfg(1, 8'h00, 8'd0, 1'b0);
    exp_done.push_back(1);
    pulse(4'b0010);
    check("size0_done", 32'(ch_done), 32'h2);
    check("size0_busy", 32'(ch_busy), 0);
    drain("size0");

    // Source backpressure mid-transfer.
    cfg(0, 8'h40, 8'd4, 1'b0);
    wr(8'h40, 8'hC0); wr(8'h41, 8'hC1);
    wr(8'h42, 8'hC2); wr(8'h43, 8'hC3);
    exp_done.push_back(0);
    pulse(4'b0001);
    wait_wr_left(3, "bp_first");
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_ready", 32'(bus.src_ready), 1);
      check("bp_no_write", 32'(bus.mem_write_enable), 0);
    end
    stall = 1'b0;
    drain("backpressure");

    // Reset during READ of byte 2.
    cfg(1, 8'h30, 8'd4, 1'b0);
    wr(8'h30, 8'h5A);
    pulse(4'b0010);
    wait_wr_left(0, "rst_first");
    step();
    check("mid_ready", 32'(bus.src_ready), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(bus.src_ready), 0);
    check("mid_rst_we", 32'(bus.mem_write_enable), 0);
    check("mid_rst_addr", 32'(bus.mem_write_address), 0);
    check("mid_rst_data", 32'(bus.mem_write_data), 0);
    check("mid_rst_act", 32'(active_ch), 0);
    check("mid_rst_busy", 32'(ch_busy), 0);
    step();
    step();
    src_q.delete();
    rst = 1'b0;
    step();
    cfg(2, 8'h70, 8'd2, 1'b0);
    wr(8'h70, 8'hD0); wr(8'h71, 8'hD1);
    exp_done.push_back(2);
    pulse(4'b0100);
    drain("after_rst");

`ifdef DMA_ABORT_EN
    // Abort active ch0 in READ of byte 2; ch1 then served.
    cfg(0, 8'h50, 8'd4, 1'b0);
    cfg(1, 8'h60, 8'd2, 1'b0);
    wr(8'h50, 8'hE0);
    pulse(4'b0011);
    wait_wr_left(0, "abort_first");
    step();
    ch_abort = 4'b0001;
    step();
    ch_abort = '0;
    check("aborted", 32'(ch_aborted), 32'h1);
    check("abort_busy0", 32'(ch_busy[0]), 0);
    wr(8'h60, 8'hF0); wr(8'h61, 8'hF1);
    exp_done.push_back(1);
    drain("abort");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
